tm1638_device_responder: RTL and testbench

Synthesizable responder for the device end of the TM1638 LED&KEY serial link, i.e. the chip side of STB/CLK/DIO. It decodes host commands, holds the 16-byte display RAM and the display-control state, and returns 4 key-scan bytes on read commands. It is used as a loopback target for the board controller in simulation and FPGA self-test, and as a board emulator when no physical TM1638 is fitted.

---
 rtl/tm1638_device_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_tm1638_device_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_device_responder.sv
// -----------------------------------------------------------------------------
// tm1638_device_responder
// Device (chip) side of the TM1638 STB/CLK/DIO serial link. Decodes host
// commands, holds the 16-byte display RAM and display-control state, and
// returns four key-scan bytes on read commands.
//
// Ports:
//   clk, rst          system clock (>= 8x sio_clk), async active-high reset
//   sio_clk           host serial clock (idles high)
//   sio_stb           host strobe, active-low
//   sio_data_in       DIO as driven by the host
//   sio_data_out(_en) DIO value/enable driven during key reads
//   key_bytes         key-scan bytes, byte n = key_bytes[8n+7:8n]
//   disp_ram          display RAM, address a = disp_ram[8a+7:8a]
//   disp_on           display-control on bit
//   brightness        display-control brightness field
//   ram_wr            1-cycle pulse per committed RAM byte
//   ram_wr_addr       address of the byte committed with ram_wr
//   frame_done        1-cycle pulse on STB rise after >= 1 complete byte
//
// Optional feature macro: TM1638_DEVICE_KEY_SNAPSHOT_EN
//   defined   -> key_bytes captured when the read command decodes
//   undefined -> each returned bit is taken live from key_bytes
// -----------------------------------------------------------------------------
module tm1638_device_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sio_clk,
  input  logic         sio_stb,
  input  logic         sio_data_in,
  output logic         sio_data_out,
  output logic         sio_data_out_en,
  input  logic [31:0]  key_bytes,
  output logic [127:0] disp_ram,
  output logic         disp_on,
  output logic [2:0]   brightness,
  output logic         ram_wr,
  output logic [3:0]   ram_wr_addr,
  output logic         frame_done
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WDATA = 3'd2,
    ST_READ  = 3'd3,
    ST_SKIP  = 3'd4
  } state_t;

  logic [SS-1:0] clk_sync_q, stb_sync_q, dat_sync_q;
  logic          clk_prev_q, stb_prev_q;

  state_t        state_q;
  logic [2:0]    bitcnt_q;
  logic [2:0]    bytecnt_q;   // saturates at 4; indices >= 4 return 0
  logic [6:0]    shift_q;     // first seven bits of the byte in flight
  logic [3:0]    addr_q;
  logic          fixed_q;
  logic          got_byte_q;
  logic [127:0]  disp_ram_q;
  logic          disp_on_q;
  logic [2:0]    bright_q;
  logic          ram_wr_q;
  logic [3:0]    ram_wr_addr_q;
  logic          frame_done_q;
  logic          dout_q;
  logic          dout_en_q;

  logic          s_clk, s_stb, s_dat;
  logic          clk_rise, clk_fall, stb_rise, stb_low;
  logic          bit_take, byte_done, cmd_state;
  logic [7:0]    byte_d;
  logic [31:0]   key_src;
  logic [7:0]    key_byte;

  // Synchronizers and previous-value flops for edge detection; the serial
  // lines reset to their idle levels so no edge is seen leaving reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= '1;
      stb_sync_q <= '1;
      dat_sync_q <= '0;
      clk_prev_q <= 1'b1;
      stb_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SS-2:0], sio_clk};
      stb_sync_q <= {stb_sync_q[SS-2:0], sio_stb};
      dat_sync_q <= {dat_sync_q[SS-2:0], sio_data_in};
      clk_prev_q <= clk_sync_q[SS-1];
      stb_prev_q <= stb_sync_q[SS-1];
    end
  end

  assign s_clk    = clk_sync_q[SS-1];
  assign s_stb    = stb_sync_q[SS-1];
  assign s_dat    = dat_sync_q[SS-1];
  assign clk_rise = s_clk & ~clk_prev_q;
  assign clk_fall = ~s_clk & clk_prev_q;
  assign stb_rise = s_stb & ~stb_prev_q;
  // A clock edge arriving together with the STB rise still belongs to the frame.
  assign stb_low  = ~(s_stb & stb_prev_q);
  assign bit_take  = clk_rise & stb_low;
  assign byte_done = bit_take & (bitcnt_q == 3'd7);
  assign byte_d    = {s_dat, shift_q};
  assign cmd_state = (state_q == ST_IDLE) || (state_q == ST_CMD);

`ifdef TM1638_DEVICE_KEY_SNAPSHOT_EN
  logic [31:0] key_snap_q;
  logic        read_cmd;
  assign read_cmd = byte_done & cmd_state & (byte_d[7:6] == 2'b01) & byte_d[1];

  // Key snapshot taken when the read command decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_snap_q <= 32'd0;
    end else if (read_cmd) begin
      key_snap_q <= key_bytes;
    end else begin
      key_snap_q <= key_snap_q;
    end
  end
  assign key_src = key_snap_q;
`else
  assign key_src = key_bytes;
`endif

  // Select the key byte currently being returned.
  always_comb begin
    key_byte = 8'h00;
    case (bytecnt_q)
      3'd0:    key_byte = key_src[7:0];
      3'd1:    key_byte = key_src[15:8];
      3'd2:    key_byte = key_src[23:16];
      3'd3:    key_byte = key_src[31:24];
      default: key_byte = 8'h00;
    endcase
  end

  // Protocol FSM, RAM, display-control state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bitcnt_q      <= 3'd0;
      bytecnt_q     <= 3'd0;
      shift_q       <= 7'd0;
      addr_q        <= 4'd0;
      fixed_q       <= 1'b0;
      got_byte_q    <= 1'b0;
      disp_ram_q    <= 128'd0;
      disp_on_q     <= 1'b0;
      bright_q      <= 3'd0;
      ram_wr_q      <= 1'b0;
      ram_wr_addr_q <= 4'd0;
      frame_done_q  <= 1'b0;
      dout_q        <= 1'b0;
      dout_en_q     <= 1'b0;
    end else begin
      ram_wr_q     <= 1'b0;
      frame_done_q <= 1'b0;

      if ((state_q == ST_IDLE) && !s_stb) begin
        state_q <= ST_CMD;
      end

      if (bit_take) begin
        shift_q  <= {s_dat, shift_q[6:1]};
        bitcnt_q <= bitcnt_q + 3'd1;
      end

      if (byte_done) begin
        got_byte_q <= 1'b1;
        if (bytecnt_q != 3'd4) begin
          bytecnt_q <= bytecnt_q + 3'd1;
        end
        if (cmd_state) begin
          case (byte_d[7:6])
            2'b01: begin
              fixed_q <= byte_d[2];
              if (byte_d[1]) begin
                state_q   <= ST_READ;
                dout_en_q <= 1'b1;
                bytecnt_q <= 3'd0;
              end else begin
                state_q <= ST_SKIP;
              end
            end
            2'b11: begin
              addr_q  <= byte_d[3:0];
              state_q <= ST_WDATA;
            end
            2'b10: begin
              disp_on_q <= byte_d[3];
              bright_q  <= byte_d[2:0];
              state_q   <= ST_SKIP;
            end
            default: state_q <= ST_SKIP;
          endcase
        end else if (state_q == ST_WDATA) begin
          disp_ram_q[{addr_q, 3'b000} +: 8] <= byte_d;
          ram_wr_q      <= 1'b1;
          ram_wr_addr_q <= addr_q;
          if (!fixed_q) begin
            addr_q <= addr_q + 4'd1;
          end
        end
      end

      if ((state_q == ST_READ) && clk_fall && !s_stb) begin
        dout_q <= key_byte[bitcnt_q];
      end

      // STB rise is handled after any byte completing in the same cycle.
      if (stb_rise) begin
        state_q      <= ST_IDLE;
        bitcnt_q     <= 3'd0;
        bytecnt_q    <= 3'd0;
        got_byte_q   <= 1'b0;
        dout_q       <= 1'b0;
        dout_en_q    <= 1'b0;
        frame_done_q <= got_byte_q | byte_done;
      end
    end
  end

  assign disp_ram        = disp_ram_q;
  assign disp_on         = disp_on_q;
  assign brightness      = bright_q;
  assign ram_wr          = ram_wr_q;
  assign ram_wr_addr     = ram_wr_addr_q;
  assign frame_done      = frame_done_q;
  assign sio_data_out    = dout_q;
  assign sio_data_out_en = dout_en_q;

endmodule

// File: tb/tb_tm1638_device_responder.sv
// Self-checking bench for tm1638_device_responder: a host bus-functional
// model drives frames, a frame-level reference model predicts RAM, control
// state, write pulses, frame_done pulses and returned key bytes.
module tb_tm1638_device_responder;
  localparam int S  = 2;
  localparam int HP = 6;   // sio_clk half period in clk cycles

  logic         clk = 1'b0;
  logic         rst;
  logic         sio_clk, sio_stb, sio_data_in;
  logic         sio_data_out, sio_data_out_en;
  logic [31:0]  key_bytes;
  logic [127:0] disp_ram;
  logic         disp_on;
  logic [2:0]   brightness;
  logic         ram_wr;
  logic [3:0]   ram_wr_addr;
  logic         frame_done;

  always #5 clk = ~clk;

  tm1638_device_responder #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .sio_clk(sio_clk), .sio_stb(sio_stb),
    .sio_data_in(sio_data_in), .sio_data_out(sio_data_out),
    .sio_data_out_en(sio_data_out_en), .key_bytes(key_bytes),
    .disp_ram(disp_ram), .disp_on(disp_on), .brightness(brightness),
    .ram_wr(ram_wr), .ram_wr_addr(ram_wr_addr), .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0]  m_ram [16];
  logic        m_fixed;
  logic        m_on;
  logic [2:0]  m_br;
  int          exp_fd;
  logic [11:0] exp_wr [$];

  // observed events
  logic [11:0] obs_wr [$];
  int          fd_cnt = 0;
  int          wr_total = 0;
  bit          chk_en = 1'b0;

  logic [7:0]  fb [20];   // bytes the host writes in a frame
  logic [7:0]  rb [8];    // bytes the host read back

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = m_ram[i];
    return r;
  endfunction

  // Event monitors
  always @(negedge clk) begin
    if (ram_wr === 1'b1) begin
      obs_wr.push_back({ram_wr_addr, disp_ram[{ram_wr_addr, 3'b000} +: 8]});
      wr_total++;
    end
    if (frame_done === 1'b1) fd_cnt++;
  end

  // Cycle compare against the model whenever the link is quiescent
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("disp_ram", disp_ram, model_flat());
      check("disp_on", {127'd0, disp_on}, {127'd0, m_on});
      check("brightness", {125'd0, brightness}, {125'd0, m_br});
      check("idle_out_en", {127'd0, sio_data_out_en}, 128'd0);
    end
  end

  task automatic hwait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sio_clk = 1'b0; sio_data_in = b; hwait(HP);
    sio_clk = 1'b1; hwait(HP);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic read_byte(output logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      sio_clk = 1'b0; sio_data_in = 1'($urandom); hwait(HP);
      v[i] = sio_data_out;
      if (i == 0) check("read_out_en", {127'd0, sio_data_out_en}, {127'd0, 1'b1});
      sio_clk = 1'b1; hwait(HP);
    end
  endtask

  // Apply one frame's rules to the model and compare frame-level results.
  task automatic model_frame(input int n, input int nrd);
    logic [7:0] cmd;
    logic [3:0] a;
    logic [7:0] e;
    if (n > 0) begin
      exp_fd++;
      cmd = fb[0];
      case (cmd[7:6])
        2'b01: begin
          m_fixed = cmd[2];
          if (cmd[1]) begin
            for (int i = 0; i < nrd; i++) begin
              e = (i < 4) ? key_bytes[8*i +: 8] : 8'h00;
              check("read_byte", {120'd0, rb[i]}, {120'd0, e});
            end
          end
        end
        2'b11: begin
          a = cmd[3:0];
          for (int i = 1; i < n; i++) begin
            m_ram[a] = fb[i];
            exp_wr.push_back({a, fb[i]});
            if (!m_fixed) a = a + 4'd1;
          end
        end
        2'b10: begin
          m_on = cmd[3];
          m_br = cmd[2:0];
        end
        default: ;
      endcase
    end
    check("wr_count", 128'(obs_wr.size()), 128'(exp_wr.size()));
    while (obs_wr.size() > 0 && exp_wr.size() > 0)
      check("wr_entry", {116'd0, obs_wr.pop_front()}, {116'd0, exp_wr.pop_front()});
    obs_wr.delete();
    exp_wr.delete();
    check("frame_done_cnt", 128'(fd_cnt), 128'(exp_fd));
  endtask

  task automatic run_frame(input int n, input int nrd, input int npart);
    chk_en = 1'b0;
    sio_stb = 1'b0; hwait(HP);
    for (int i = 0; i < n; i++) send_byte(fb[i]);
    for (int i = 0; i < nrd; i++) read_byte(rb[i]);
    for (int i = 0; i < npart; i++) send_bit(1'($urandom));
    hwait(HP);
    sio_stb = 1'b1;
    hwait(S + 2);
    check("out_en_after_stb", {127'd0, sio_data_out_en}, 128'd0);
    hwait(8);
    model_frame(n, nrd);
    chk_en = 1'b1;
    hwait(2);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
    m_fixed = 1'b0; m_on = 1'b0; m_br = 3'd0;
  endtask

  initial begin
    int fd0, wr0, kind, n, nrd, np;
    logic [7:0] keep;
    rst = 1'b1; sio_clk = 1'b1; sio_stb = 1'b1; sio_data_in = 1'b0;
    key_bytes = 32'd0;
    exp_fd = 0;
    model_reset();
    hwait(4);
    check("rst_disp_ram", disp_ram, 128'd0);
    check("rst_ctrl", {120'd0, disp_on, brightness, ram_wr, frame_done, sio_data_out, sio_data_out_en},
          128'd0);
    rst = 1'b0;
    hwait(4);
    chk_en = 1'b1;

    // Test 1: reset mid-WDATA after three writes
    fb[0] = 8'h8F; run_frame(1, 0, 0);
    chk_en = 1'b0;
    sio_stb = 1'b0; hwait(HP);
    send_byte(8'hC0); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    hwait(HP);
    exp_wr.push_back({4'd0, 8'h12}); exp_wr.push_back({4'd1, 8'h34});
    exp_wr.push_back({4'd2, 8'h56});
    check("t1_wr_count", 128'(obs_wr.size()), 128'd3);
    rst = 1'b1;
    #1;
    check("t1_rst_ram", disp_ram, 128'd0);
    check("t1_rst_out_en", {127'd0, sio_data_out_en}, 128'd0);
    check("t1_rst_disp_on", {127'd0, disp_on}, 128'd0);
    sio_stb = 1'b1; sio_clk = 1'b1;
    hwait(4);
    rst = 1'b0;
    model_reset();
    hwait(4);
    model_frame(0, 0);
    fb[0] = 8'hC0; fb[1] = 8'h55; run_frame(2, 0, 0);
    check("t1_addr0", {120'd0, disp_ram[7:0]}, 128'h55);

    // Test 2: fill RAM with its own addresses
    fd0 = fd_cnt; wr0 = wr_total;
    fb[0] = 8'h40; run_frame(1, 0, 0);
    fb[0] = 8'hC0;
    for (int i = 0; i < 16; i++) fb[i+1] = 8'(i);
    run_frame(17, 0, 0);
    check("t2_ram", disp_ram, 128'h0F0E0D0C0B0A09080706050403020100);
    check("t2_wr_pulses", 128'(wr_total - wr0), 128'd16);
    check("t2_frame_done", 128'(fd_cnt - fd0), 128'd2);

    // Test 3: auto-increment wraps 15 -> 0
    fb[0] = 8'h40; run_frame(1, 0, 0);
    fb[0] = 8'hCE; fb[1] = 8'hAA; fb[2] = 8'hBB; fb[3] = 8'hCC; run_frame(4, 0, 0);
    check("t3_addr14", {120'd0, disp_ram[119:112]}, 128'hAA);
    check("t3_addr15", {120'd0, disp_ram[127:120]}, 128'hBB);
    check("t3_addr0", {120'd0, disp_ram[7:0]}, 128'hCC);

    // Test 4: fixed address
    keep = m_ram[4];
    fb[0] = 8'h44; run_frame(1, 0, 0);
    fb[0] = 8'hC3; fb[1] = 8'h11; fb[2] = 8'h22; run_frame(3, 0, 0);
    check("t4_addr3", {120'd0, disp_ram[31:24]}, 128'h22);
    check("t4_addr4", {120'd0, disp_ram[39:32]}, {120'd0, keep});

    // Test 5: key read, five bytes
    key_bytes = 32'h0010_0111;
    fb[0] = 8'h42; run_frame(1, 5, 0);
    check("t5_rd0", {120'd0, rb[0]}, 128'h11);
    check("t5_rd1", {120'd0, rb[1]}, 128'h01);
    check("t5_rd2", {120'd0, rb[2]}, 128'h10);
    check("t5_rd3", {120'd0, rb[3]}, 128'h00);
    check("t5_rd4", {120'd0, rb[4]}, 128'h00);

    // Test 6: display control and an aborted frame
    fb[0] = 8'h8D; run_frame(1, 0, 0);
    check("t6_on", {127'd0, disp_on}, 128'd1);
    check("t6_br", {125'd0, brightness}, 128'd5);
    fb[0] = 8'h80; run_frame(1, 0, 0);
    check("t6_off", {124'd0, disp_on, brightness}, 128'd0);
    fd0 = fd_cnt;
    run_frame(0, 0, 5);
    check("t6_abort_fd", 128'(fd_cnt), 128'(fd0));

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      key_bytes = $urandom;
      kind = $urandom_range(0, 5);
      n = 1; nrd = 0; np = 0;
      case (kind)
        0: fb[0] = 8'h40 | 8'($urandom_range(0, 1) << 2);
        1: begin
          fb[0] = 8'hC0 | 8'($urandom_range(0, 15));
          n = 1 + $urandom_range(0, 6);
          for (int i = 1; i < n; i++) fb[i] = 8'($urandom);
          np = $urandom_range(0, 7);
        end
        2: fb[0] = 8'h80 | 8'($urandom_range(0, 15));
        3: begin
          fb[0] = 8'h42 | 8'($urandom_range(0, 1) << 2);
          nrd = $urandom_range(0, 6);
        end
        4: begin
          n = 1 + $urandom_range(0, 2);
          for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
          np = $urandom_range(0, 7);
        end
        default: begin
          n = 0;
          np = $urandom_range(1, 7);
        end
      endcase
      run_frame(n, nrd, np);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
